// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage
//
// Sits directly behind the execute stage. Non-memory instructions are copied
// into the writeback registers with one cycle of latency. Loads and stores are
// captured into a request register set, presented on the data bus until the
// slave answers with dbus_ready (or the timeout expires), and the upstream
// pipeline is held with mem_stall for the duration of the access.
//
// Parameters
//   BUS_TIMEOUT  REQ cycles without dbus_ready before the access is aborted
//                (0 disables the timeout)
//   CNT_W        width of the timeout counter, must be able to hold BUS_TIMEOUT
//
// Ports
//   clk, rst                 core clock, asynchronous active-low reset
//   ex_reg_wen/_waddr        destination write enable / register from EX
//   ex_alu_out               ALU result, byte address for memory ops
//   ex_ill_instr             illegal-instruction flag from EX
//   ex_mem_read/_write       load / store request (both set -> store)
//   ex_mem_funct3            access size and signedness (B, H, W, BU, HU)
//   ex_mem_wdata             store data (rs2)
//   mem_stall                holds EX/ID/IF while an access is pending
//   dbus_req/_we/_addr       bus request, write flag, word-aligned address
//   dbus_wdata/_byte_en      lane-replicated store data and byte strobes
//   dbus_ready/_rdata        access complete / read word
//   mem_reg_wen/_waddr/_wdata writeback enable, register and data
//   mem_ill_instr            illegal flag passed through
//   mem_misaligned           one-cycle pulse on a misaligned access
//   mem_bus_err              one-cycle pulse on a bus timeout
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int BUS_TIMEOUT = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ex_reg_wen,
  input  logic [4:0]  ex_reg_waddr,
  input  logic [31:0] ex_alu_out,
  input  logic        ex_ill_instr,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_wdata,

  output logic        mem_stall,

  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_byte_en,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata,

  output logic        mem_reg_wen,
  output logic [4:0]  mem_reg_waddr,
  output logic [31:0] mem_reg_wdata,
  output logic        mem_ill_instr,
  output logic        mem_misaligned,
  output logic        mem_bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Request registers: everything the bus and the load formatter need,
  // frozen at the IDLE->REQ edge so the bus sees stable values.
  logic [29:0]      req_addr_reg;
  logic [1:0]       req_off_reg;
  logic [31:0]      req_wdata_reg;
  logic [3:0]       req_be_reg;
  logic [2:0]       req_funct3_reg;
  logic [4:0]       req_waddr_reg;
  logic             req_wen_reg;
  logic             req_we_reg;

  // Writeback registers.
  logic             wb_wen_reg;
  logic [4:0]       wb_waddr_reg;
  logic [31:0]      wb_wdata_reg;
  logic             ill_reg;
  logic             misaligned_reg;
  logic             bus_err_reg;

  // ---------------------------------------------------------------------------
  // Decode of the instruction presented by EX
  // ---------------------------------------------------------------------------
  logic mem_op;
  logic acc_byte;
  logic acc_half;
  logic acc_word;
  logic op_misaligned;
  logic op_aligned;

  // An illegal instruction never touches the bus, it just carries its flag on.
  assign mem_op   = (ex_mem_read | ex_mem_write) & ~ex_ill_instr;
  assign acc_byte = (ex_mem_funct3[1:0] == 2'b00);
  assign acc_half = (ex_mem_funct3[1:0] == 2'b01);
  // funct3[1] covers W; the unused encodings 011/11x also behave as a word.
  assign acc_word = ex_mem_funct3[1];

  assign op_misaligned = mem_op &
                         ((acc_half & ex_alu_out[0]) |
                          (acc_word & (|ex_alu_out[1:0])));
  assign op_aligned    = mem_op & ~op_misaligned;

  // ---------------------------------------------------------------------------
  // Store strobes and lane replication
  // ---------------------------------------------------------------------------
  logic [3:0]  store_be_base;
  logic [3:0]  store_be;
  logic [31:0] store_data;

  always_comb begin
    store_be_base = 4'b1111;
    if (acc_byte) begin
      store_be_base = 4'b0001;
    end else if (acc_half) begin
      store_be_base = 4'b0011;
    end
  end

  // Aligned words always have offset 0, so one shift serves all sizes.
  assign store_be = store_be_base << ex_alu_out[1:0];

  // Each byte lane picks its source byte: a byte store puts wdata[7:0] on
  // every lane, a half store alternates the two low bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_store_lane
      assign store_data[8*gi +: 8] =
        acc_byte ? ex_mem_wdata[7:0] :
        acc_half ? ex_mem_wdata[8*(gi%2) +: 8] :
                   ex_mem_wdata[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load formatting, driven by the captured offset and funct3
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        load_signed;
  logic [31:0] load_data;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_load_lane
      assign rd_byte[gi] = dbus_rdata[8*gi +: 8];
    end
  endgenerate

  assign load_byte   = rd_byte[req_off_reg];
  assign load_half   = req_off_reg[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
  assign load_signed = ~req_funct3_reg[2];

  always_comb begin
    load_data = dbus_rdata;
    case (req_funct3_reg[1:0])
      2'b00:   load_data = {{24{load_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{load_signed & load_half[15]}}, load_half};
      default: load_data = dbus_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus timeout: fires in the REQ cycle where the counter has reached
  // BUS_TIMEOUT-1 and the slave still has not answered. A ready in that same
  // cycle wins.
  // ---------------------------------------------------------------------------
  logic timeout_hit;

  generate
    if (BUS_TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (state_reg == REQ) && !dbus_ready &&
                           (cnt_reg == CNT_W'(BUS_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stall: raised as soon as an aligned access shows up in IDLE, held through
  // REQ, and dropped in the completing (ready or timeout) cycle so EX advances
  // on that same edge. Gated by rst so it is low while reset is asserted even
  // if EX still presents a memory op.
  // ---------------------------------------------------------------------------
  assign mem_stall = rst &
                     (((state_reg == IDLE) & op_aligned) |
                      ((state_reg == REQ) & ~dbus_ready & ~timeout_hit));

  // ---------------------------------------------------------------------------
  // Control FSM and all registered state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      req_addr_reg   <= '0;
      req_off_reg    <= '0;
      req_wdata_reg  <= '0;
      req_be_reg     <= '0;
      req_funct3_reg <= '0;
      req_waddr_reg  <= '0;
      req_wen_reg    <= 1'b0;
      req_we_reg     <= 1'b0;
      wb_wen_reg     <= 1'b0;
      wb_waddr_reg   <= '0;
      wb_wdata_reg   <= '0;
      ill_reg        <= 1'b0;
      misaligned_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      misaligned_reg <= 1'b0;
      bus_err_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (op_aligned) begin
            req_addr_reg   <= ex_alu_out[31:2];
            req_off_reg    <= ex_alu_out[1:0];
            req_wdata_reg  <= store_data;
            req_be_reg     <= store_be;
            req_funct3_reg <= ex_mem_funct3;
            req_waddr_reg  <= ex_reg_waddr;
            req_wen_reg    <= ex_reg_wen;
            req_we_reg     <= ex_mem_write;
            cnt_reg        <= '0;
            wb_wen_reg     <= 1'b0;   // bubble while the access runs
            ill_reg        <= 1'b0;
            state_reg      <= REQ;
          end else if (op_misaligned) begin
            wb_wen_reg     <= 1'b0;
            ill_reg        <= 1'b0;
            misaligned_reg <= 1'b1;
          end else begin
            wb_wen_reg     <= ex_reg_wen;
            wb_waddr_reg   <= ex_reg_waddr;
            wb_wdata_reg   <= ex_alu_out;
            ill_reg        <= ex_ill_instr;
          end
        end

        REQ: begin
          wb_wen_reg <= 1'b0;
          ill_reg    <= 1'b0;
          if (dbus_ready) begin
            if (!req_we_reg) begin
              wb_wen_reg   <= req_wen_reg;
              wb_waddr_reg <= req_waddr_reg;
              wb_wdata_reg <= load_data;
            end
            state_reg <= IDLE;
          end else if (timeout_hit) begin
            bus_err_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign dbus_req       = (state_reg == REQ);
  assign dbus_we        = req_we_reg;
  assign dbus_addr      = {req_addr_reg, 2'b00};
  assign dbus_wdata     = req_wdata_reg;
  assign dbus_byte_en   = req_be_reg;

  assign mem_reg_wen    = wb_wen_reg;
  assign mem_reg_waddr  = wb_waddr_reg;
  assign mem_reg_wdata  = wb_wdata_reg;
  assign mem_ill_instr  = ill_reg;
  assign mem_misaligned = misaligned_reg;
  assign mem_bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage
//
// Directed instructions are issued one cycle at a time. Each issue task works
// out, from the access rules (size, alignment, lane selection, extension,
// timeout length), what every DUT output must be in each cycle it spans; a
// compare process checks those expectations on every falling edge. A few
// literal checks pin the expected values of the key scenarios.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        ex_reg_wen;
  logic [4:0]  ex_reg_waddr;
  logic [31:0] ex_alu_out;
  logic        ex_ill_instr;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_wdata;
  logic        mem_stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byte_en;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;
  logic        mem_reg_wen;
  logic [4:0]  mem_reg_waddr;
  logic [31:0] mem_reg_wdata;
  logic        mem_ill_instr;
  logic        mem_misaligned;
  logic        mem_bus_err;

  mem_stage #(.BUS_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_reg_wen     (ex_reg_wen),
    .ex_reg_waddr   (ex_reg_waddr),
    .ex_alu_out     (ex_alu_out),
    .ex_ill_instr   (ex_ill_instr),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_funct3  (ex_mem_funct3),
    .ex_mem_wdata   (ex_mem_wdata),
    .mem_stall      (mem_stall),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_wdata     (dbus_wdata),
    .dbus_byte_en   (dbus_byte_en),
    .dbus_ready     (dbus_ready),
    .dbus_rdata     (dbus_rdata),
    .mem_reg_wen    (mem_reg_wen),
    .mem_reg_waddr  (mem_reg_waddr),
    .mem_reg_wdata  (mem_reg_wdata),
    .mem_ill_instr  (mem_ill_instr),
    .mem_misaligned (mem_misaligned),
    .mem_bus_err    (mem_bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values for the current cycle (e_*) and for after the next edge
  // (n_*). Registered outputs move from n_* to e_* at every clock step.
  logic        e_stall, e_req;
  logic        e_wen, e_ill, e_mis, e_berr;
  logic [4:0]  e_waddr;
  logic [31:0] e_wbd;
  logic [31:0] e_baddr, e_bwdata;
  logic [3:0]  e_bbe;
  logic        e_bwe;
  logic        n_wen, n_ill, n_mis, n_berr;
  logic [4:0]  n_waddr;
  logic [31:0] n_wbd;
  logic [31:0] n_baddr, n_bwdata;
  logic [3:0]  n_bbe;
  logic        n_bwe;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    e_stall = 0; e_req = 0; e_wen = 0; e_ill = 0; e_mis = 0; e_berr = 0;
    e_waddr = 0; e_wbd = 0; e_baddr = 0; e_bwdata = 0; e_bbe = 0; e_bwe = 0;
    n_wen = 0; n_ill = 0; n_mis = 0; n_berr = 0;
    n_waddr = 0; n_wbd = 0; n_baddr = 0; n_bwdata = 0; n_bbe = 0; n_bwe = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e_wen = n_wen; e_waddr = n_waddr; e_wbd = n_wbd; e_ill = n_ill;
    e_mis = n_mis; e_berr = n_berr;
    e_baddr = n_baddr; e_bwdata = n_bwdata; e_bbe = n_bbe; e_bwe = n_bwe;
  endtask

  // Load result from the access rules: shift the addressed lane down, then
  // extend through signed/unsigned integer types.
  function automatic logic [31:0] fmt(input logic [2:0] f3, input int off,
                                      input logic [31:0] w);
    logic [31:0] s;
    byte         sb;
    shortint     sh;
    s  = w >> (8 * off);
    sb = s[7:0];
    sh = s[15:0];
    case (f3)
      3'b000:  return 32'(int'(sb));
      3'b100:  return {24'b0, s[7:0]};
      3'b001:  return 32'(int'(sh));
      3'b101:  return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Compare process: every output, every cycle while checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",      32'(mem_stall),      32'(e_stall));
      check("dbus_req",   32'(dbus_req),       32'(e_req));
      check("wb_wen",     32'(mem_reg_wen),    32'(e_wen));
      check("ill",        32'(mem_ill_instr),  32'(e_ill));
      check("misaligned", 32'(mem_misaligned), 32'(e_mis));
      check("bus_err",    32'(mem_bus_err),    32'(e_berr));
      if (e_wen) begin
        check("wb_waddr", 32'(mem_reg_waddr), 32'(e_waddr));
        check("wb_wdata", mem_reg_wdata, e_wbd);
      end
      if (e_req) begin
        check("dbus_addr", dbus_addr, e_baddr);
        check("dbus_we",   32'(dbus_we), 32'(e_bwe));
        if (e_bwe) begin
          check("dbus_be",    32'(dbus_byte_en), 32'(e_bbe));
          check("dbus_wdata", dbus_wdata, e_bwdata);
        end
      end
    end
  end

  // One non-memory instruction (rd may be set only together with ill).
  task automatic do_alu(input logic wen, input logic [4:0] waddr,
                        input logic [31:0] alu, input logic ill, input logic rd);
    step();
    ex_reg_wen = wen; ex_reg_waddr = waddr; ex_alu_out = alu;
    ex_ill_instr = ill; ex_mem_read = rd; ex_mem_write = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_wdata = 32'h0;
    dbus_ready = 1'b0; dbus_rdata = 32'h0;
    e_stall = 0; e_req = 0;
    n_wen = wen; n_waddr = waddr; n_wbd = alu; n_ill = ill; n_mis = 0; n_berr = 0;
  endtask

  // One memory instruction. delay = REQ cycles without ready before ready
  // (negative: never). Returns in the last cycle of the access.
  task automatic do_mem(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic wen,
                        input logic [4:0] waddr, input int delay,
                        input logic idle_ready);
    int size;
    int off;
    step();
    ex_reg_wen = wen; ex_reg_waddr = waddr; ex_alu_out = addr;
    ex_ill_instr = 1'b0; ex_mem_read = rd; ex_mem_write = wr;
    ex_mem_funct3 = f3; ex_mem_wdata = sdata;
    dbus_ready = idle_ready; dbus_rdata = ~rdata;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr[1:0]);
    e_req = 0;
    n_wen = 0; n_ill = 0; n_mis = 0; n_berr = 0;
    if ((off % size) != 0) begin
      e_stall = 0;
      n_mis   = 1;
      return;
    end
    e_stall  = 1;
    n_baddr  = {addr[31:2], 2'b00};
    n_bwe    = wr;
    n_bbe    = 4'(((1 << size) - 1) << off);
    n_bwdata = (size == 1) ? {4{sdata[7:0]}} :
               (size == 2) ? {2{sdata[15:0]}} : sdata;
    for (int k = 0; k < TO; k++) begin
      step();
      e_req = 1;
      n_wen = 0; n_ill = 0; n_mis = 0; n_berr = 0;
      if (k == delay) begin
        dbus_ready = 1'b1;
        dbus_rdata = rdata;
        e_stall    = 0;
        if (!wr) begin
          n_wen = wen; n_waddr = waddr; n_wbd = fmt(f3, off, rdata);
        end
        return;
      end
      dbus_ready = 1'b0;
      dbus_rdata = 32'h0BAD_0000 + 32'(k);
      if (k == TO - 1) begin
        e_stall = 0;
        n_berr  = 1;
        return;
      end
      e_stall = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    ex_reg_wen = 0; ex_reg_waddr = 0; ex_alu_out = 0; ex_ill_instr = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_mem_funct3 = 0; ex_mem_wdata = 0;
    dbus_ready = 0; dbus_rdata = 0;
    model_clear();

    // Reset state
    @(posedge clk); @(posedge clk); #3;
    check("rst_wen",   32'(mem_reg_wen), 32'd0);
    check("rst_req",   32'(dbus_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wdata", mem_reg_wdata, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // ALU pass-through
    do_alu(1, 5'd5, 32'h0000_1234, 0, 0);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_alu_wen",   32'(mem_reg_wen), 32'd1);
    check("lit_alu_waddr", 32'(mem_reg_waddr), 32'd5);
    check("lit_alu_wdata", mem_reg_wdata, 32'h0000_1234);

    // Illegal load passes through as a plain instruction with its flag
    do_alu(1, 5'd3, 32'h0000_1000, 1, 1);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_ill_flag", 32'(mem_ill_instr), 32'd1);

    // LB signed, ready in the first REQ cycle
    do_mem(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 5'd6, 0, 0);
    check("lit_lb_addr", dbus_addr, 32'h0000_1000);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_lb_wdata", mem_reg_wdata, 32'hFFFF_FF80);
    check("lit_lb_waddr", 32'(mem_reg_waddr), 32'd6);

    // LBU same address and data
    do_mem(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 5'd7, 0, 0);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_lbu_wdata", mem_reg_wdata, 32'h0000_0080);

    // Back-to-back LH / LHU, then LW with a stray ready in IDLE
    do_mem(1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_1234, 1, 5'd8, 1, 0);
    do_mem(1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'h8001_1234, 1, 5'd9, 0, 0);
    do_mem(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'h1357_9BDF, 1, 5'd10, 2, 1);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_lw_wdata", mem_reg_wdata, 32'h1357_9BDF);

    // SH with ready delayed 3 cycles
    do_mem(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 5'd0, 3, 0);
    check("lit_sh_be",    32'(dbus_byte_en), 32'hC);
    check("lit_sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    check("lit_sh_we",    32'(dbus_we), 32'd1);
    check("lit_sh_addr",  dbus_addr, 32'h0000_2000);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_sh_wen", 32'(mem_reg_wen), 32'd0);

    // SB, SW, and read+write together (treated as a store)
    do_mem(0, 1, 3'b000, 32'h0000_2001, 32'h1234_565A, 32'h0, 0, 5'd0, 0, 0);
    check("lit_sb_be", 32'(dbus_byte_en), 32'h2);
    do_mem(0, 1, 3'b010, 32'h0000_2000, 32'hA1B2_C3D4, 32'h0, 0, 5'd0, 1, 0);
    do_mem(1, 1, 3'b010, 32'h0000_2004, 32'h1122_3344, 32'hFFFF_FFFF, 1, 5'd13, 0, 0);
    check("lit_rw_we", 32'(dbus_we), 32'd1);

    // Misaligned accesses
    do_mem(1, 0, 3'b010, 32'h0000_2001, 32'h0, 32'h0, 1, 5'd9, 0, 1);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_mis_pulse", 32'(mem_misaligned), 32'd1);
    check("lit_mis_wen",   32'(mem_reg_wen), 32'd0);
    do_mem(1, 0, 3'b001, 32'h0000_2003, 32'h0, 32'h0, 1, 5'd9, 0, 0);
    do_mem(0, 1, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 0, 5'd0, 0, 0);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_mis_clear", 32'(mem_misaligned), 32'd0);

    // Timeout, then a normal ALU op
    do_mem(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 1, 5'd10, -1, 0);
    do_alu(1, 5'd11, 32'hCAFE_F00D, 0, 0);
    check("lit_to_err", 32'(mem_bus_err), 32'd1);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_to_alu", mem_reg_wdata, 32'hCAFE_F00D);

    // Reset in the middle of a REQ
    do_alu(1, 5'd7, 32'hDEAD_BEEF, 0, 0);
    step();
    ex_reg_wen = 1; ex_reg_waddr = 5'd14; ex_alu_out = 32'h0000_3000;
    ex_mem_read = 1; ex_mem_write = 0; ex_mem_funct3 = 3'b010;
    dbus_ready = 0;
    e_stall = 1; e_req = 0;
    n_wen = 0; n_ill = 0; n_mis = 0; n_berr = 0;
    n_baddr = 32'h0000_3000; n_bwe = 0; n_bbe = 4'hF; n_bwdata = 32'h0;
    step();
    e_req = 1; e_stall = 1;
    #6;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check("lit_arst_req",   32'(dbus_req), 32'd0);
    check("lit_arst_stall", 32'(mem_stall), 32'd0);
    check("lit_arst_wdata", mem_reg_wdata, 32'd0);
    check("lit_arst_addr",  dbus_addr, 32'd0);
    check("lit_arst_be",    32'(dbus_byte_en), 32'd0);
    ex_reg_wen = 0; ex_reg_waddr = 0; ex_alu_out = 0; ex_mem_read = 0;
    ex_mem_funct3 = 0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    model_clear();
    chk_en = 1'b1;

    // After reset: state is IDLE, pass-through and a load work again
    do_alu(1, 5'd12, 32'h55AA_55AA, 0, 0);
    do_mem(1, 0, 3'b000, 32'h0000_1001, 32'h0, 32'h0000_7F00, 1, 5'd15, 0, 0);
    do_alu(0, 5'd0, 32'h0, 0, 0);
    check("lit_post_lb", mem_reg_wdata, 32'h0000_007F);
    do_alu(0, 5'd0, 32'h0, 0, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
